vend_ctrl_param: RTL

Parametrised vending controller, the successor to the fixed 5/10/20-coin, single-price vending machine.
- Accepts coded coins and accumulates a balance (saldo).
- Vends once the balance reaches the price of the selected product.
- Returns change greedily, one coin per handshake.
- Supports a cancel/refund mode and rejects coins that would overflow the balance.
- Sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vend_ctrl_param_if.sv | 31 +++
 rtl/vend_ctrl_param.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_param_if.sv
`default_nettype none
// ============================================================================
// vend_ctrl_param_if : coin-acceptor / dispenser / hopper signal bundle
// Revision: 1.0
// ============================================================================
interface vend_ctrl_param_if #(
  parameter int SALDO_W = 8
);
  logic [1:0]         moeda;
  logic               sel;
  logic               cancel;
  logic               troco_ack;
  logic               vendeu;
  logic               prod;
  logic               moeda_rej;
  logic               troco_valid;
  logic [1:0]         troco_moeda;
  logic [SALDO_W-1:0] saldo;
  logic               ocupado;

  modport slave (
    input  moeda, sel, cancel, troco_ack,
    output vendeu, prod, moeda_rej, troco_valid, troco_moeda, saldo, ocupado
  );

  modport master (
    output moeda, sel, cancel, troco_ack,
    input  vendeu, prod, moeda_rej, troco_valid, troco_moeda, saldo, ocupado
  );
endinterface
`default_nettype wire

// File: rtl/vend_ctrl_param.sv
`default_nettype none
// ============================================================================
// vend_ctrl_param : parametrised vending controller, coin balance + greedy change
// Revision: 1.0
// ============================================================================
module vend_ctrl_param #(
  parameter int SALDO_W   = 8,
  parameter int V1        = 5,
  parameter int V2        = 10,
  parameter int V3        = 20,
  parameter int PRICE_A   = 40,
  parameter int PRICE_B   = 65,
  parameter int MAX_SALDO = 100
) (
  input  logic             clk,
  input  logic             res,
  vend_ctrl_param_if.slave bus
);

  localparam int c_w = SALDO_W + 1;
  localparam logic [SALDO_W:0] c_v1    = c_w'(V1);
  localparam logic [SALDO_W:0] c_v2    = c_w'(V2);
  localparam logic [SALDO_W:0] c_v3    = c_w'(V3);
  localparam logic [SALDO_W:0] c_pa    = c_w'(PRICE_A);
  localparam logic [SALDO_W:0] c_pb    = c_w'(PRICE_B);
  localparam logic [SALDO_W:0] c_max   = c_w'(MAX_SALDO);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACUM  = 2'd1,
    S_VENDE = 2'd2,
    S_TROCO = 2'd3
  } state_t;

  function automatic logic [SALDO_W:0] coin_val(input logic [1:0] code);
    case (code)
      2'b01:   coin_val = c_v1;
      2'b10:   coin_val = c_v2;
      2'b11:   coin_val = c_v3;
      default: coin_val = '0;
    endcase
  endfunction

  // Largest coin code that still fits into the remaining amount.
  function automatic logic [1:0] greedy(input logic [SALDO_W:0] amount);
    if (amount >= c_v3)      greedy = 2'b11;
    else if (amount >= c_v2) greedy = 2'b10;
    else if (amount >= c_v1) greedy = 2'b01;
    else                     greedy = 2'b00;
  endfunction

  state_t             r_state, w_state_nx;
  logic [SALDO_W-1:0] r_saldo, w_saldo_nx;
  logic               r_vendeu, w_vendeu_nx;
  logic               r_prod, w_prod_nx;
  logic               r_sel, w_sel_nx;
  logic               r_rej, w_rej_nx;
  logic               r_tvalid, w_tvalid_nx;
  logic [1:0]         r_tcode, w_tcode_nx;
  logic               r_ocupado;

  logic [SALDO_W:0]   w_saldo_ext;
  logic [SALDO_W:0]   w_sum;
  logic [SALDO_W:0]   w_price_now;
  logic [SALDO_W:0]   w_rem;
  logic [SALDO_W:0]   w_after;
  logic               w_coin;

  assign w_saldo_ext = {1'b0, r_saldo};
  assign w_coin      = (bus.moeda != 2'b00);
  assign w_sum       = w_saldo_ext + coin_val(bus.moeda);
  assign w_price_now = bus.sel ? c_pb : c_pa;
  assign w_rem       = w_saldo_ext - (r_sel ? c_pb : c_pa);
  assign w_after     = w_saldo_ext - coin_val(r_tcode);

  always_comb begin
    w_state_nx  = r_state;
    w_saldo_nx  = r_saldo;
    w_vendeu_nx = 1'b0;
    w_prod_nx   = 1'b0;
    w_sel_nx    = r_sel;
    w_rej_nx    = 1'b0;
    w_tvalid_nx = r_tvalid;
    w_tcode_nx  = r_tcode;

    case (r_state)
      S_IDLE, S_ACUM: begin
        if ((r_state == S_ACUM) && bus.cancel) begin
          // Refund wins over a coin arriving in the same cycle.
          w_rej_nx = w_coin;
          if (w_saldo_ext >= c_v1) begin
            w_state_nx  = S_TROCO;
            w_tvalid_nx = 1'b1;
            w_tcode_nx  = greedy(w_saldo_ext);
          end else begin
            w_state_nx = S_IDLE;
            w_saldo_nx = '0;
          end
        end else if (w_coin) begin
          if (w_sum > c_max) begin
            w_rej_nx = 1'b1;
          end else begin
            w_saldo_nx = w_sum[SALDO_W-1:0];
            if (w_sum >= w_price_now) begin
              w_state_nx = S_VENDE;
              w_sel_nx   = bus.sel;
            end else begin
              w_state_nx = S_ACUM;
            end
          end
        end
      end

      S_VENDE: begin
        w_vendeu_nx = 1'b1;
        w_prod_nx   = r_sel;
        w_rej_nx    = w_coin;
        if (w_rem >= c_v1) begin
          w_state_nx  = S_TROCO;
          w_saldo_nx  = w_rem[SALDO_W-1:0];
          w_tvalid_nx = 1'b1;
          w_tcode_nx  = greedy(w_rem);
        end else begin
          w_state_nx = S_IDLE;
          w_saldo_nx = '0;
        end
      end

      S_TROCO: begin
        w_rej_nx = w_coin;
        if (bus.troco_ack) begin
          // A sub-V1 residue cannot be paid out, so it is dropped here.
          if (w_after < c_v1) begin
            w_state_nx  = S_IDLE;
            w_saldo_nx  = '0;
            w_tvalid_nx = 1'b0;
            w_tcode_nx  = 2'b00;
          end else begin
            w_saldo_nx = w_after[SALDO_W-1:0];
            w_tcode_nx = greedy(w_after);
          end
        end
      end

      default: begin
        w_state_nx  = S_IDLE;
        w_saldo_nx  = '0;
        w_tvalid_nx = 1'b0;
        w_tcode_nx  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state   <= S_IDLE;
      r_saldo   <= '0;
      r_vendeu  <= 1'b0;
      r_prod    <= 1'b0;
      r_sel     <= 1'b0;
      r_rej     <= 1'b0;
      r_tvalid  <= 1'b0;
      r_tcode   <= 2'b00;
      r_ocupado <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_saldo   <= w_saldo_nx;
      r_vendeu  <= w_vendeu_nx;
      r_prod    <= w_prod_nx;
      r_sel     <= w_sel_nx;
      r_rej     <= w_rej_nx;
      r_tvalid  <= w_tvalid_nx;
      r_tcode   <= w_tcode_nx;
      r_ocupado <= (w_state_nx == S_VENDE) || (w_state_nx == S_TROCO);
    end
  end

  assign bus.vendeu      = r_vendeu;
  assign bus.prod        = r_prod;
  assign bus.moeda_rej   = r_rej;
  assign bus.troco_valid = r_tvalid;
  assign bus.troco_moeda = r_tcode;
  assign bus.saldo       = r_saldo;
  assign bus.ocupado     = r_ocupado;

endmodule
`default_nettype wire
